pal_cfg_loader: RTL and testbench
=================================

Name: pal_cfg_loader

Overview:
- Host-side serializer that produces the PAL configuration bitstream.
- Accepts configuration bytes over a valid/ready handshake, shifts them out one bit at a time on a generated slow configuration clock, then asserts the apply-enable line.
- Sits between a host/controller and the PAL fabric's cfg/clk/en pins; it is the transmitting end of the PAL configuration shift interface.

Parameters:
- CFG_BITS, 240, total configuration bits to shift (2*8*12 AND-plane + 12*4 OR-plane for the 8/12/4 PAL).
- CLK_DIV, 2, `clk` cycles per `cfg_clk` half-period; must be >= 1.

Ports:
- clk  input  1  system clock
- res  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a new load (ignored while busy)
- din  input  8  configuration byte
- din_valid  input  1  din holds a valid byte
- din_ready  output  1  loader accepts din this cycle
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when the apply phase completes
- cfg_clk  output  1  configuration shift clock to the PAL
- cfg_data  output  1  configuration serial bit to the PAL
- cfg_en  output  1  apply-enable to the PAL
- crc  output  8  CRC of the shifted bitstream (optional feature)

Behaviour:
- Reset values: din_ready=0, busy=0, done=0, cfg_clk=0, cfg_data=0, cfg_en=0, crc=0. State goes to IDLE and all counters clear.
- Reset mid-load behaves identically: the load is aborted and cfg_en=0.
- FSM states are IDLE, FETCH, SHIFT, APPLY, HOLD.
- IDLE:
  - Entered from reset.
  - On start=1: cfg_en<=0, bit counter<=0, go to FETCH, busy<=1.
- FETCH:
  - din_ready=1.
  - On din_valid && din_ready, latch din into the shift register and go to SHIFT.
  - din_ready is 0 in every other state.
  - Throughput: one byte per 8 bits shifted.
- SHIFT:
  - Each bit has a low phase of CLK_DIV cycles then a high phase of CLK_DIV cycles, so one bit takes 2*CLK_DIV cycles.
  - cfg_data is updated only at the start of the low phase, from shift-register bit 0 (LSB first; bit 0 of the first byte goes first).
  - cfg_clk rises after CLK_DIV low cycles; the PAL samples on that edge.
  - At the end of the high phase, cfg_clk returns to 0, the shift register shifts right and the bit counter increments.
  - After the 8th bit of a byte: go to FETCH if the bit counter < CFG_BITS, else APPLY.
  - If CFG_BITS is not a multiple of 8, the unused upper bits of the last byte are discarded and never driven.
- Stall: while FETCH waits on din_valid, cfg_clk stays 0 and cfg_data holds its last value. No spurious edges.
- APPLY:
  - cfg_en=1 and cfg_data=0.
  - Issue exactly one further cfg_clk pulse (CLK_DIV low, CLK_DIV high) so the PAL latches the configuration.
  - Then pulse done=1 for one cycle, drop busy, go to HOLD.
- HOLD:
  - cfg_en stays 1 (fabric operational) and cfg_clk stays 0.
  - start=1 returns to FETCH with cfg_en<=0 in the same edge.
- start while busy=1 is ignored.
- start and din_valid in the same IDLE cycle: din is not accepted; din_ready first goes high in the cycle after start.
- The bit counter is $clog2(CFG_BITS+1) bits wide and never wraps.
- The divider counter is $clog2(CLK_DIV) bits wide (minimum 1).

Optional Feature:
- Macro: PAL_CFG_LOADER_CRC_EN
- Defined:
  - crc computes CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Fed with each cfg_data bit at its cfg_clk rising edge, in shift order (LSB-first bitstream).
  - Cleared on start. Valid and stable from done onward until the next start.
- Undefined: crc is tied to 8'h00 and no CRC logic is generated.

Test Plan:
- Reset: assert res for 3 cycles mid-SHIFT -> next cycle cfg_en=0, cfg_clk=0, busy=0, din_ready=0; state IDLE.
- Basic load (CFG_BITS=16, CLK_DIV=2): start, bytes 8'hA5 then 8'h3C with din_valid always high -> cfg_data sampled at 16 cfg_clk rises = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; then one APPLY rise with cfg_en=1; done pulses once; elapsed 17*4 cycles plus handshake cycles.
- Stall: hold din_valid=0 for 20 cycles between the two bytes -> no cfg_clk edges during the gap, cfg_data unchanged, bitstream identical to the basic load.
- Partial byte (CFG_BITS=12): bytes 8'hFF, 8'h0F -> exactly 12 rising edges of cfg_clk before APPLY, all sampled bits 1; the upper nibble of the second byte is never driven.
- Re-start: after done, pulse start while cfg_en=1 -> cfg_en falls the next cycle, din_ready=1; a start pulsed during SHIFT is ignored (bit count unaffected).
- CRC (macro defined, CFG_BITS=8): byte 8'h01 -> bitstream 1,0,0,0,0,0,0,0; crc at done equals the reference-model CRC-8/0x07 of that bit sequence. Macro undefined -> crc=8'h00 throughout.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serializes configuration bytes LSB-first onto the PAL cfg_clk/cfg_data pins, then raises cfg_en.
// Optional CRC-8 (poly 0x07) over the shifted bitstream is enabled by defining PAL_CFG_LOADER_CRC_EN.
`timescale 1ns/1ps
module pal_cfg_loader #(
  parameter int CFG_BITS = 240,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       busy,
  output logic       done,
  output logic       cfg_clk,
  output logic       cfg_data,
  output logic       cfg_en,
  output logic [7:0] crc
);

  localparam int BW = $clog2(CFG_BITS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, APPLY, HOLD} state_t;

  state_t        state;
  logic [7:0]    sreg;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    byte_bit;
  logic [DW-1:0] div_cnt;
  logic          phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

`ifdef PAL_CFG_LOADER_CRC_EN
  logic [7:0] crc_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign crc = crc_q;
`else
  assign crc = '0;
`endif

  // sreg holds only the bits still to be driven; cfg_data already carries the current bit.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      byte_bit  <= '0;
      div_cnt   <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_clk   <= 1'b0;
      cfg_data  <= 1'b0;
      cfg_en    <= 1'b0;
`ifdef PAL_CFG_LOADER_CRC_EN
      crc_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            din_ready <= 1'b1;
            cfg_en    <= 1'b0;
            bit_cnt   <= '0;
`ifdef PAL_CFG_LOADER_CRC_EN
            crc_q     <= '0;
`endif
          end
        end

        FETCH: begin
          if (din_valid && din_ready) begin
            sreg      <= {1'b0, din[7:1]};
            cfg_data  <= din[0];
            din_ready <= 1'b0;
            byte_bit  <= '0;
            div_cnt   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!cfg_clk) begin
              cfg_clk <= 1'b1;
`ifdef PAL_CFG_LOADER_CRC_EN
              crc_q   <= crc8_step(crc_q, cfg_data);
`endif
            end else begin
              cfg_clk  <= 1'b0;
              sreg     <= {1'b0, sreg[7:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              byte_bit <= byte_bit + 1'b1;
              // A partial final byte ends here, before its upper bits are ever driven.
              if (bit_cnt == LAST_BIT) begin
                state    <= APPLY;
                cfg_en   <= 1'b1;
                cfg_data <= 1'b0;
              end else if (byte_bit == 3'd7) begin
                state     <= FETCH;
                din_ready <= 1'b1;
              end else begin
                cfg_data <= sreg[0];
              end
            end
          end
        end

        APPLY: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!cfg_clk) begin
              cfg_clk <= 1'b1;
            end else begin
              cfg_clk <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= HOLD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: two instances (16 bits / CLK_DIV 2 and 12 bits / CLK_DIV 1)
// checked against a bitstream/CRC model built from the loaded bytes.
`timescale 1ns/1ps
module tb_pal_cfg_loader;

  localparam int BITS0 = 16;
  localparam int DIV0  = 2;
  localparam int BITS1 = 12;
  localparam int DIV1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res[2];
  logic       start[2];
  logic       din_valid[2];
  logic [7:0] din[2];
  logic       din_ready_w[2], busy_w[2], done_w[2];
  logic       cfg_clk_w[2], cfg_data_w[2], cfg_en_w[2];
  logic [7:0] crc_w[2];

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int          cap_n[2];
  logic        cap_bits[2][4096];
  int          apply_rises[2];
  int          apply_bad[2];
  int          done_cnt[2];
  int unsigned done_cyc[2];
  int          glitch[2];
  int          crc_nz[2];
  bit          prev_clk[2];
  logic        prev_data[2];

  pal_cfg_loader #(.CFG_BITS(BITS0), .CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .res(res[0]), .start(start[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .cfg_clk(cfg_clk_w[0]), .cfg_data(cfg_data_w[0]), .cfg_en(cfg_en_w[0]), .crc(crc_w[0])
  );

  pal_cfg_loader #(.CFG_BITS(BITS1), .CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .res(res[1]), .start(start[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .cfg_clk(cfg_clk_w[1]), .cfg_data(cfg_data_w[1]), .cfg_en(cfg_en_w[1]), .crc(crc_w[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pin-level observer: what the PAL would see on each cfg_clk rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cfg_clk_w[d] === 1'b1 && !prev_clk[d]) begin
        if (cfg_en_w[d] === 1'b1) begin
          apply_rises[d]++;
          if (cfg_data_w[d] !== 1'b0) apply_bad[d]++;
        end else begin
          if (cap_n[d] < 4096) cap_bits[d][cap_n[d]] = cfg_data_w[d];
          cap_n[d]++;
        end
      end
      if (prev_clk[d] && cfg_clk_w[d] === 1'b1 && cfg_data_w[d] !== prev_data[d]) glitch[d]++;
      if (done_w[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (crc_w[d] !== 8'h00) crc_nz[d]++;
      prev_clk[d]  = (cfg_clk_w[d] === 1'b1);
      prev_data[d] = cfg_data_w[d];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, first shifted bit = highest order.
  function automatic logic [7:0] model_crc(input logic [15:0] stream, input int n);
    logic [8:0] rem;
    rem = '0;
    for (int i = 0; i < n + 8; i++) begin
      rem = {rem[7:0], (i < n) ? stream[i] : 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic load2(input int d, input logic [7:0] b0, input logic [7:0] b1,
                       input bit stall, input bit mid_start, input string tag);
    int          nbits, div, base_n, base_ap, base_bad, base_done, base_gl, guard, gap_n, stall_bad;
    int unsigned t0, exp_lat;
    logic [15:0] stream;
    logic        gap_data;
    nbits     = (d == 0) ? BITS0 : BITS1;
    div       = (d == 0) ? DIV0 : DIV1;
    stream    = {b1, b0};
    base_n    = cap_n[d];
    base_ap   = apply_rises[d];
    base_bad  = apply_bad[d];
    base_done = done_cnt[d];
    base_gl   = glitch[d];
    stall_bad = 0;

    start[d] = 1'b1; din_valid[d] = 1'b1; din[d] = b0; t0 = cyc;
    checks++;
    if (din_ready_w[d] !== 1'b0) begin
      errors++; $display("FAIL %s ready_at_start: got %b want 0", tag, din_ready_w[d]);
    end
    step();
    start[d] = 1'b0;
    checks++;
    if (din_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b1 || cfg_en_w[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_start: ready/busy/en got %b%b%b want 110", tag,
               din_ready_w[d], busy_w[d], cfg_en_w[d]);
    end
`ifdef PAL_CFG_LOADER_CRC_EN
    checks++;
    if (crc_w[d] !== 8'h00) begin
      errors++; $display("FAIL %s crc_cleared: got %h want 00", tag, crc_w[d]);
    end
`endif
    step();
    din_valid[d] = !stall; din[d] = b1;
    guard = 0;
    while (din_ready_w[d] !== 1'b1 && guard < 1000) begin step(); guard++; end
    checks++;
    if (guard >= 1000) begin
      errors++; $display("FAIL %s wait_ready: got timeout want din_ready", tag);
    end
    if (stall) begin
      gap_data = cfg_data_w[d];
      gap_n    = cap_n[d];
      repeat (20) begin
        step();
        if (cfg_clk_w[d] !== 1'b0 || cfg_data_w[d] !== gap_data) stall_bad++;
      end
      checks++;
      if (stall_bad != 0 || cap_n[d] != gap_n || gap_data !== b0[7]) begin
        errors++;
        $display("FAIL %s stall: bad_cycles %0d rises %0d data %b want 0 0 %b", tag,
                 stall_bad, cap_n[d] - gap_n, gap_data, b0[7]);
      end
      din_valid[d] = 1'b1;
    end
    step();
    din_valid[d] = 1'b0;
    if (mid_start) begin
      repeat (2) step();
      start[d] = 1'b1;
      step();
      start[d] = 1'b0;
      checks++;
      if (busy_w[d] !== 1'b1 || din_ready_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s start_in_shift: busy/ready got %b%b want 10", tag, busy_w[d], din_ready_w[d]);
      end
    end

    guard = 0;
    while (done_cnt[d] == base_done && guard < 2000) begin step(); guard++; end
    checks++;
    if (guard >= 2000) begin
      errors++; $display("FAIL %s wait_done: got timeout want done", tag);
    end
    repeat (3) step();

    checks++;
    if (done_cnt[d] - base_done != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt[d] - base_done);
    end
    checks++;
    if (cap_n[d] - base_n != nbits) begin
      errors++; $display("FAIL %s bit_count: got %0d want %0d", tag, cap_n[d] - base_n, nbits);
    end
    for (int i = 0; i < nbits; i++) begin
      checks++;
      if (base_n + i >= 4096 || cap_bits[d][base_n + i] !== stream[i]) begin
        errors++;
        $display("FAIL %s bit%0d: got %b want %b", tag, i,
                 (base_n + i < 4096) ? cap_bits[d][base_n + i] : 1'bx, stream[i]);
      end
    end
    checks++;
    if (apply_rises[d] - base_ap != 1 || apply_bad[d] != base_bad) begin
      errors++;
      $display("FAIL %s apply_pulse: rises %0d data_bad %0d want 1 0", tag,
               apply_rises[d] - base_ap, apply_bad[d] - base_bad);
    end
    checks++;
    if (glitch[d] != base_gl) begin
      errors++; $display("FAIL %s data_while_high: got %0d changes want 0", tag, glitch[d] - base_gl);
    end
    checks++;
    if (busy_w[d] !== 1'b0 || cfg_en_w[d] !== 1'b1 || cfg_clk_w[d] !== 1'b0 || din_ready_w[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: busy/en/clk/ready got %b%b%b%b want 0100", tag,
               busy_w[d], cfg_en_w[d], cfg_clk_w[d], din_ready_w[d]);
    end
    checks++;
`ifdef PAL_CFG_LOADER_CRC_EN
    if (crc_w[d] !== model_crc(stream, nbits)) begin
      errors++; $display("FAIL %s crc: got %h want %h", tag, crc_w[d], model_crc(stream, nbits));
    end
`else
    if (crc_w[d] !== 8'h00) begin
      errors++; $display("FAIL %s crc: got %h want 00", tag, crc_w[d]);
    end
`endif
    if (!stall) begin
      exp_lat = 2 + (nbits + 1) * 2 * div + 1;
      checks++;
      if (done_cyc[d] - t0 != exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", tag, done_cyc[d] - t0, exp_lat);
      end
    end
  endtask

  task automatic test_reset();
    int base, guard;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (din_ready_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 ||
          cfg_clk_w[d] !== 1'b0 || cfg_data_w[d] !== 1'b0 || cfg_en_w[d] !== 1'b0 || crc_w[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset_values dut%0d: ready/busy/done/clk/data/en %b%b%b%b%b%b crc %h want 000000 00",
                 d, din_ready_w[d], busy_w[d], done_w[d], cfg_clk_w[d], cfg_data_w[d], cfg_en_w[d], crc_w[d]);
      end
    end
    base = cap_n[0];
    start[0] = 1'b1; din_valid[0] = 1'b1; din[0] = 8'hC3;
    step();
    start[0] = 1'b0;
    guard = 0;
    while (cap_n[0] < base + 3 && guard < 500) begin step(); guard++; end
    din_valid[0] = 1'b0;
    checks++;
    if (guard >= 500) begin
      errors++; $display("FAIL reset_reach_shift: got timeout want 3 rises");
    end
    res[0] = 1'b1;
    repeat (3) step();
    res[0] = 1'b0;
    step();
    checks++;
    if (cfg_en_w[0] !== 1'b0 || cfg_clk_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || din_ready_w[0] !== 1'b0 ||
        cfg_data_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: en/clk/busy/ready/data/done got %b%b%b%b%b%b want 000000",
               cfg_en_w[0], cfg_clk_w[0], busy_w[0], din_ready_w[0], cfg_data_w[0], done_w[0]);
    end
    base = cap_n[0];
    repeat (10) step();
    checks++;
    if (cap_n[0] != base || busy_w[0] !== 1'b0) begin
      errors++; $display("FAIL reset_idle: rises %0d busy %b want 0 0", cap_n[0] - base, busy_w[0]);
    end
  endtask

  task automatic test_basic();
    load2(0, 8'hA5, 8'h3C, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    load2(0, 8'hA5, 8'h3C, 1'b1, 1'b0, "stall");
  endtask

  task automatic test_partial();
    load2(1, 8'hFF, 8'h0F, 1'b0, 1'b0, "partial");
  endtask

  task automatic test_restart();
    load2(0, 8'($urandom), 8'($urandom), 1'b0, 1'b1, "restart0");
    load2(1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, "restart1");
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 8; k++) begin
      d = int'($urandom_range(0, 1));
      load2(d, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_crc();
    load2(0, 8'h01, 8'h00, 1'b0, 1'b0, "crc_01");
    load2(1, 8'h80, 8'h09, 1'b0, 1'b0, "crc_partial");
`ifndef PAL_CFG_LOADER_CRC_EN
    checks++;
    if (crc_nz[0] != 0 || crc_nz[1] != 0) begin
      errors++; $display("FAIL crc_tied: nonzero cycles %0d/%0d want 0/0", crc_nz[0], crc_nz[1]);
    end
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      res[d] = 1'b1; start[d] = 1'b0; din_valid[d] = 1'b0; din[d] = 8'h00;
    end
    repeat (3) step();
    res[0] = 1'b0; res[1] = 1'b0;
    step();
    test_reset();
    test_basic();
    test_stall();
    test_partial();
    test_restart();
    test_random();
    test_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
